// File: rtl/dlf_iir_mac.sv
// rtl/dlf_iir_mac.sv - time-multiplexed direct-form-I IIR loop filter with a single shared MAC
module dlf_iir_mac #(
    parameter int DW    = 8,
    parameter int ORDER = 3,
    parameter int CI    = 2,
    parameter int CF    = 18,
    localparam int CW   = CI + CF,
    parameter int ACC_W = DW + CW + 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DW-1:0]        in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DW-1:0]        out_data,
    output logic                 out_valid,
    output logic                 out_sat,
    input  logic                 hold,
    input  logic                 clr,
    input  logic                 cfg_we,
    input  logic [3:0]           cfg_addr,
    input  logic [CW-1:0]        cfg_wdata,
    input  logic                 cfg_commit
);

    localparam int SW = 4;
    localparam logic [SW-1:0] LAST_STEP = SW'(2 * ORDER);
    localparam logic signed [ACC_W:0] HALF    = (ACC_W + 1)'(1) << (CF - 1);
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W + 1)'(2 ** (DW - 1) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = -((ACC_W + 1)'(2 ** (DW - 1)));
    localparam logic [DW-1:0] OUT_MAX = {1'b0, {(DW - 1){1'b1}}};
    localparam logic [DW-1:0] OUT_MIN = {1'b1, {(DW - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;

    state_t state, state_nx;

    logic signed [CW-1:0] shd_b [0:ORDER];
    logic signed [CW-1:0] shd_a [1:ORDER];
    logic signed [CW-1:0] act_b [0:ORDER];
    logic signed [CW-1:0] act_a [1:ORDER];
    logic signed [DW-1:0] x_hist [0:ORDER];
    logic signed [DW-1:0] y_hist [1:ORDER];

    logic                    commit_pend;
    logic                    start;
    logic                    do_commit;
    logic [SW-1:0]           step;
    logic signed [ACC_W-1:0] acc;
    logic signed [CW-1:0]    mac_coef;
    logic signed [DW-1:0]    mac_data;
    logic                    mac_sub;
    logic signed [DW+CW-1:0] prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W:0]   rnd_sum;
    logic signed [ACC_W:0]   rnd_shift;
    logic [DW-1:0]           sat_data;
    logic                    sat_flag;

    assign start = (state == IDLE) && in_valid && !hold && !clr;

    // A commit coinciding with a real accept is deferred so the new sample sees the old bank.
    assign do_commit = (cfg_commit || commit_pend) &&
                       ((state == ROUND) || ((state == IDLE) && !start));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = MAC;
            MAC:     if (clr) state_nx = IDLE;
                     else if (step == LAST_STEP) state_nx = ROUND;
            ROUND:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE) && !clr;
    end

    // Step order: b0..bORDER against x history, then a1..aORDER against y history.
    always_comb begin
        mac_coef = '0;
        mac_data = '0;
        mac_sub  = 1'b0;
        for (int k = 0; k <= ORDER; k++) begin
            if (step == SW'(k)) begin
                mac_coef = act_b[k];
                mac_data = x_hist[k];
            end
        end
        for (int k = 1; k <= ORDER; k++) begin
            if (step == SW'(ORDER + k)) begin
                mac_coef = act_a[k];
                mac_data = y_hist[k];
                mac_sub  = 1'b1;
            end
        end
    end

    assign prod      = mac_coef * mac_data;
    assign prod_ext  = ACC_W'(prod);
    assign rnd_sum   = {acc[ACC_W-1], acc} + HALF;
    assign rnd_shift = rnd_sum >>> CF;

    always_comb begin
        sat_data = rnd_shift[DW-1:0];
        sat_flag = 1'b0;
        if (rnd_shift > SAT_MAX) begin
            sat_data = OUT_MAX;
            sat_flag = 1'b1;
        end else if (rnd_shift < SAT_MIN) begin
            sat_data = OUT_MIN;
            sat_flag = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_pend <= 1'b0;
            for (int k = 0; k <= ORDER; k++) begin
                shd_b[k] <= '0;
                act_b[k] <= '0;
            end
            for (int k = 1; k <= ORDER; k++) begin
                shd_a[k] <= '0;
                act_a[k] <= '0;
            end
        end else begin
            if (cfg_we) begin
                for (int k = 0; k <= ORDER; k++) begin
                    if (cfg_addr == 4'(k)) shd_b[k] <= cfg_wdata;
                end
                for (int k = 1; k <= ORDER; k++) begin
                    if (cfg_addr == 4'(8 + k)) shd_a[k] <= cfg_wdata;
                end
            end
            if (do_commit) begin
                act_b       <= shd_b;
                act_a       <= shd_a;
                commit_pend <= 1'b0;
            end else if (cfg_commit) begin
                commit_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            step      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
            for (int k = 0; k <= ORDER; k++) x_hist[k] <= '0;
            for (int k = 1; k <= ORDER; k++) y_hist[k] <= '0;
        end else begin
            out_valid <= 1'b0;
            if (clr) begin
                acc      <= '0;
                step     <= '0;
                out_data <= '0;
                out_sat  <= 1'b0;
                for (int k = 0; k <= ORDER; k++) x_hist[k] <= '0;
                for (int k = 1; k <= ORDER; k++) y_hist[k] <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid && hold) begin
                            out_valid <= 1'b1;
                            out_sat   <= 1'b0;
                        end else if (in_valid) begin
                            x_hist[0] <= in_data;
                            for (int k = 1; k <= ORDER; k++) x_hist[k] <= x_hist[k-1];
                            acc  <= '0;
                            step <= '0;
                        end
                    end
                    MAC: begin
                        acc  <= mac_sub ? (acc - prod_ext) : (acc + prod_ext);
                        step <= step + 1'b1;
                    end
                    ROUND: begin
                        out_data  <= sat_data;
                        out_sat   <= sat_flag;
                        out_valid <= 1'b1;
                        y_hist[1] <= sat_data;
                        for (int k = 2; k <= ORDER; k++) y_hist[k] <= y_hist[k-1];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dlf_iir_mac.sv
// tb/tb_dlf_iir_mac.sv - randomized scoreboard bench for dlf_iir_mac against a behavioural filter model
module tb_dlf_iir_mac;

    localparam int DW = 8;
    localparam int CW = 20;
    localparam int ONE = 262144;
    localparam int HALF_C = 131072;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_sat;
    logic          hold = 1'b0;
    logic          clr = 1'b0;
    logic          cfg_we = 1'b0;
    logic [3:0]    cfg_addr = '0;
    logic [CW-1:0] cfg_wdata = '0;
    logic          cfg_commit = 1'b0;

    dlf_iir_mac dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_sat(out_sat), .hold(hold), .clr(clr),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     data;
        bit     sat;
        longint cyc;
    } exp_t;

    exp_t   sbq[$];
    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;

    // Reference model state: coefficient banks and sample histories as plain integers.
    int sb [0:3];
    int sa [1:3];
    int ab [0:3];
    int aa [1:3];
    int mx [0:3];
    int my [1:3];
    int last_out;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sbq.size() == 0) begin
                fail_now("unexpected_out_valid");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("out_data", longint'($signed(out_data)), e.data);
                chk("out_sat", longint'(out_sat), longint'(e.sat));
                chk("latency", cyc, e.cyc);
            end
        end
    end

    function automatic void model_clear();
        for (int k = 0; k <= 3; k++) mx[k] = 0;
        for (int k = 1; k <= 3; k++) my[k] = 0;
        last_out = 0;
    endfunction

    function automatic void model_reset();
        model_clear();
        for (int k = 0; k <= 3; k++) begin sb[k] = 0; ab[k] = 0; end
        for (int k = 1; k <= 3; k++) begin sa[k] = 0; aa[k] = 0; end
    endfunction

    // y = sum(b*x) - sum(a*y), rounded half up to integer, clipped to the signed 8-bit range.
    function automatic void model_sample(input int d, output int yo, output bit so);
        longint acc;
        longint r;
        for (int k = 3; k >= 1; k--) mx[k] = mx[k-1];
        mx[0] = d;
        acc = 0;
        for (int k = 0; k <= 3; k++) acc += longint'(ab[k]) * mx[k];
        for (int k = 1; k <= 3; k++) acc -= longint'(aa[k]) * my[k];
        r = (acc + HALF_C) >>> 18;
        so = 1'b0;
        if (r > 127) begin r = 127; so = 1'b1; end
        if (r < -128) begin r = -128; so = 1'b1; end
        yo = int'(r);
        for (int k = 3; k >= 2; k--) my[k] = my[k-1];
        my[1] = yo;
        last_out = yo;
    endfunction

    task automatic send(input int d, input bit h, input bit expect_out);
        int   budget;
        exp_t e;
        budget = 200;
        @(negedge clk);
        in_data  = d[DW-1:0];
        hold     = h;
        in_valid = 1'b1;
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!in_ready) begin
            fail_now("in_ready_wait");
            in_valid = 1'b0;
            hold     = 1'b0;
            return;
        end
        if (expect_out) begin
            if (h) begin
                e.data = last_out;
                e.sat  = 1'b0;
                e.cyc  = cyc + 1;
            end else begin
                model_sample(d, e.data, e.sat);
                e.cyc = cyc + 1 + 8;
            end
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        hold     = 1'b0;
    endtask

    task automatic cfg(input int addr, input int val);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = addr[3:0];
        cfg_wdata = val[CW-1:0];
        if (addr >= 0 && addr <= 3) sb[addr] = val;
        if (addr >= 9 && addr <= 11) sa[addr-8] = val;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic commit();
        @(negedge clk);
        cfg_commit = 1'b1;
        @(posedge clk);
        #1;
        cfg_commit = 1'b0;
        ab = sb;
        aa = sa;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_clear();
    endtask

    task automatic drain();
        int budget;
        budget = 300;
        while (sbq.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (sbq.size() != 0) begin
            fail_now("drain");
            sbq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic quiet_window(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_out_data", longint'(out_data), 0);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_out_sat", longint'(out_sat), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", longint'(in_ready), 1);

        // Impulse through b0 = 1.0
        cfg(0, ONE);
        commit();
        send(5, 1'b0, 1'b1);
        drain();

        // Saturation with b0 = b1 = 1.0; illegal addresses must not land anywhere
        cfg(4, ONE);
        cfg(8, ONE);
        cfg(12, ONE);
        cfg(1, ONE);
        commit();
        do_clr();
        send(100, 1'b0, 1'b1);
        send(100, 1'b0, 1'b1);
        drain();
        do_clr();
        send(-100, 1'b0, 1'b1);
        send(-100, 1'b0, 1'b1);
        drain();

        // First-order feedback step response, a1 = -0.5
        cfg(1, 0);
        cfg(9, -HALF_C);
        commit();
        do_clr();
        for (int i = 0; i < 8; i++) send(64, 1'b0, 1'b1);
        drain();

        // Round-half-up with b0 = 0.5
        cfg(9, 0);
        cfg(0, HALF_C);
        commit();
        do_clr();
        send(3, 1'b0, 1'b1);
        send(-3, 1'b0, 1'b1);
        send(1, 1'b0, 1'b1);
        drain();

        // Commit while busy: in-flight sample keeps b0 = 1.0
        cfg(0, ONE);
        commit();
        do_clr();
        send(8, 1'b0, 1'b1);
        cfg(0, HALF_C);
        commit();
        send(8, 1'b0, 1'b1);
        drain();

        // Hold must not disturb x history: b1 = 1.0 exposes any stray shift
        cfg(1, ONE);
        commit();
        send(50, 1'b1, 1'b1);
        send(2, 1'b0, 1'b1);
        drain();

        // clr at MAC cycle 3 aborts without out_valid
        send(20, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        do_clr();
        @(negedge clk);
        chk("clr_out_data", longint'(out_data), 0);
        chk("clr_in_ready", longint'(in_ready), 1);
        quiet_window(12);
        send(6, 1'b0, 1'b1);
        drain();

        // Randomized coefficients, samples, holds and gaps
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k <= 3; k++) cfg(k, int'($urandom_range(262143)) - HALF_C);
            for (int k = 1; k <= 3; k++) cfg(8 + k, int'($urandom_range(131071)) - 65536);
            cfg(4 + int'($urandom_range(3)), int'($urandom_range(262143)));
            commit();
            do_clr();
            for (int i = 0; i < 20; i++) begin
                send(int'($urandom_range(255)) - 128, ($urandom_range(7) == 0), 1'b1);
                repeat ($urandom_range(3)) @(negedge clk);
            end
            drain();
        end

        // Asynchronous reset mid-MAC clears both banks and produces no output
        send(30, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_in_ready", longint'(in_ready), 1);
        quiet_window(12);
        send(77, 1'b0, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
